// File: rtl/if_pkg.sv
// Shared types for the fetch-address generator: reset PC default, the
// per-packet metadata captured at request time, the full queue entry, and
// the request-side state encoding.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  // Captured when the I-cache accepts a request.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken1;
    logic        pred_taken2;
    logic [31:0] pred_addr;
  } fetch_meta_t;

  // One fetch-queue slot: metadata plus the 64-bit {inst1, inst0} payload.
  typedef struct packed {
    fetch_meta_t meta;
    logic [63:0] rdata;
  } fetch_entry_t;

  // ST_RUN : normal fetching from if_pc.
  // ST_HOLD: a redirect arrived while a request was pending; the stale
  //          request is kept on the bus until the cache accepts it.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/if_pc_gen_if.sv
// I-cache request/response bus between the fetch-address generator
// (master) and the instruction cache (slave).
//
// Handshakes: a request transfers on a cycle where inst_req and
// inst_addr_ok are both high; inst_addr is held stable while inst_req is
// high and inst_addr_ok is low. inst_data_ok is a one-cycle response strobe
// with no backpressure; responses return strictly in request order.
interface if_pc_gen_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order fetch queue with three pointers:
//   wr_ptr   - next slot to receive metadata when a request is accepted
//   fill_ptr - next slot to receive response data
//   rd_ptr   - head slot presented to decode
// Pointers carry one extra MSB as a wrap bit. A flush drops every issued
// and buffered packet by pulling wr_ptr and fill_ptr back to rd_ptr.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 3
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             push,
  input  fetch_meta_t      push_meta,
  input  logic             fill,
  input  logic [63:0]      fill_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             head_valid,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] in_flight
);

  localparam int               IDX_W   = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  fetch_meta_t      meta_mem [QDEPTH];
  logic [63:0]      data_mem [QDEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fill_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign fill_idx = fill_ptr[IDX_W-1:0];
  assign rd_idx   = rd_ptr[IDX_W-1:0];

  // Pointer updates; a flush overrides push/fill, pop is gated upstream.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else if (flush) begin
      wr_ptr   <= rd_ptr;
      fill_ptr <= rd_ptr;
    end else begin
      if (push) wr_ptr   <= wr_ptr + ONE;
      if (fill) fill_ptr <= fill_ptr + ONE;
      if (pop)  rd_ptr   <= rd_ptr + ONE;
    end
  end

  // Slot storage; cleared on reset so idle outputs read as zero.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        meta_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push && !flush) meta_mem[wr_idx]   <= push_meta;
      if (fill && !flush) data_mem[fill_idx] <= fill_data;
    end
  end

  assign full       = ((wr_ptr - rd_ptr) == DEPTH_V);
  assign head_valid = (fill_ptr != rd_ptr);
  assign head       = '{meta: meta_mem[rd_idx], rdata: data_mem[rd_idx]};
  assign in_flight  = wr_ptr - fill_ptr;

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-address generator: drives if_pc to the branch predictor, issues
// 64-bit fetch requests at if_pc, follows the predicted next PC, and buffers
// responses in issue order for decode. A backend redirect discards every
// in-flight and buffered packet; responses still owed for discarded
// requests are counted in cancel_cnt and dropped on arrival.
// Optional build macro IF_PERF_CNT_EN adds redirect / dropped-response
// performance counters.
module if_pc_gen
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 4,
  parameter int          CNT_W    = 3
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic [31:0] if_pc,
  input  logic        pred_taken1,
  input  logic        pred_taken2,
  input  logic [31:0] pred_addr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  if_pc_gen_if.master icache,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic        out_valid1,
  output logic        out_pred_taken1,
  output logic        out_pred_taken2,
  output logic [31:0] out_pred_addr,
  output pc_state_e   dbg_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);

  localparam logic [CNT_W:0] C_ZERO = '0;

  pc_state_e        state;
  pc_state_e        state_nxt;
  logic [31:0]      pc_nxt;
  logic [31:0]      hold_addr;
  logic [CNT_W:0]   cancel_cnt;
  logic [CNT_W:0]   cancel_nxt;
  logic             q_full;
  logic             q_push;
  logic             q_fill;
  logic             q_pop;
  logic             head_valid;
  fetch_entry_t     head;
  fetch_meta_t      push_meta;
  logic [CNT_W-1:0] in_flight;
  logic             accept;
  logic             drop;

  assign icache.inst_req  = !cpu_rst && (((state == ST_RUN) && !q_full) || (state == ST_HOLD));
  assign icache.inst_addr = (state == ST_HOLD) ? hold_addr : if_pc;

  assign accept = icache.inst_req && icache.inst_addr_ok;
  assign drop   = icache.inst_data_ok && (cancel_cnt != C_ZERO);
  assign q_push = accept && (state == ST_RUN) && !redirect_valid;
  assign q_fill = icache.inst_data_ok && (cancel_cnt == C_ZERO) && !redirect_valid;
  assign q_pop  = head_valid && out_ready && !redirect_valid;

  assign push_meta = '{pc: if_pc, pred_taken1: pred_taken1,
                       pred_taken2: pred_taken2, pred_addr: pred_addr};

  if_fetch_queue #(
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_queue (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .push       (q_push),
    .push_meta  (push_meta),
    .fill       (q_fill),
    .fill_data  (icache.inst_rdata),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .full       (q_full),
    .head_valid (head_valid),
    .head       (head),
    .in_flight  (in_flight)
  );

  // Next PC, next state and cancel count; redirect wins over everything.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = if_pc;
    cancel_nxt = cancel_cnt;
    if (redirect_valid) begin
      pc_nxt     = redirect_pc;
      // Every response still owed becomes a cancel: old cancels, requests
      // not yet answered, plus a request accepted this cycle, less a
      // response consumed this cycle.
      cancel_nxt = cancel_cnt + {1'b0, in_flight} + {{CNT_W{1'b0}}, accept}
                   - {{CNT_W{1'b0}}, icache.inst_data_ok};
      case (state)
        ST_RUN:  if (icache.inst_req && !icache.inst_addr_ok) state_nxt = ST_HOLD;
        ST_HOLD: if (accept) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end else begin
      cancel_nxt = cancel_cnt + {{CNT_W{1'b0}}, accept && (state == ST_HOLD)}
                   - {{CNT_W{1'b0}}, drop};
      case (state)
        ST_RUN:  if (accept) pc_nxt = pred_addr;
        ST_HOLD: if (accept) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // State, PC and cancel-count registers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= ST_RUN;
      if_pc      <= RESET_PC;
      cancel_cnt <= '0;
    end else begin
      state      <= state_nxt;
      if_pc      <= pc_nxt;
      cancel_cnt <= cancel_nxt;
    end
  end

  // Capture the stale address when a redirect strands a pending request.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      hold_addr <= '0;
    end else if (redirect_valid && (state == ST_RUN) && icache.inst_req && !icache.inst_addr_ok) begin
      hold_addr <= if_pc;
    end
  end

  assign out_valid       = head_valid;
  assign out_pc          = head.meta.pc;
  assign out_inst0       = head.rdata[31:0];
  assign out_inst1       = head.rdata[63:32];
  assign out_valid1      = head_valid && !head.meta.pred_taken1;
  assign out_pred_taken1 = head.meta.pred_taken1;
  assign out_pred_taken2 = head.meta.pred_taken2;
  assign out_pred_addr   = head.meta.pred_addr;
  assign dbg_state       = state;

`ifdef IF_PERF_CNT_EN
  // Count redirect cycles and responses thrown away.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      perf_redirect_cnt <= '0;
      perf_cancel_cnt   <= '0;
    end else begin
      if (redirect_valid) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      if (icache.inst_data_ok && ((cancel_cnt != C_ZERO) || redirect_valid))
        perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: acts as predictor, I-cache and decode. The reference
// model keeps the ordered list of accepted requests (live or discarded) and
// the packets decode should see, and derives request/stall behaviour from
// occupancy counts.
module tb_if_pc_gen;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  // clock / reset
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  logic [31:0] if_pc;
  logic        pred_taken1, pred_taken2;
  logic [31:0] pred_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst0, out_inst1, out_pred_addr;
  logic        out_valid1, out_pred_taken1, out_pred_taken2;
  pc_state_e   dbg_state;

  if_pc_gen_if bus ();

  if_pc_gen dut (
    .cpu_clk         (cpu_clk),
    .cpu_rst         (cpu_rst),
    .if_pc           (if_pc),
    .pred_taken1     (pred_taken1),
    .pred_taken2     (pred_taken2),
    .pred_addr       (pred_addr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .icache          (bus),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst0       (out_inst0),
    .out_inst1       (out_inst1),
    .out_valid1      (out_valid1),
    .out_pred_taken1 (out_pred_taken1),
    .out_pred_taken2 (out_pred_taken2),
    .out_pred_addr   (out_pred_addr),
    .dbg_state       (dbg_state)
  );

  // reference model state
  // fly entry: [66] live, [65:34] pc, [33] t1, [32] t2, [31:0] pred_addr
  logic [66:0]  fly_q[$];
  // decode packet: {pc, t1, t2, pred_addr, rdata}
  logic [129:0] exp_q[$];
  logic [31:0]  issued_q[$];
  logic [31:0]  consumed_q[$];
  logic [31:0]  model_pc, hold_addr_m;
  bit           hold_m;
  int           checks = 0;
  int           errors = 0;

  // stimulus knobs (percent) and directed overrides
  int           p_addr, p_data, p_ready, p_redir, p_taken;
  bit           f_redir;
  logic [31:0]  f_redir_pc;
  bit           ft_en;
  logic [31:0]  ft_pc, ft_target;

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {a ^ 32'ha5a5_0f0f, ~a};
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (fly_q[i]) if (fly_q[i][66]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, check, then advance model.
  task automatic step();
    logic [31:0]  cur;
    logic [66:0]  f;
    logic [129:0] hm;
    bit           exp_req, acc, pop;
    @(negedge cpu_clk);
    cur     = hold_m ? hold_addr_m : model_pc;
    exp_req = hold_m || ((live_cnt() + exp_q.size()) < 4);

    if (ft_en && (if_pc == ft_pc)) begin
      pred_taken1 = 1'b1; pred_taken2 = 1'b0; pred_addr = ft_target;
    end else begin
      pred_taken1 = ($urandom_range(0, 99) < p_taken);
      pred_taken2 = !pred_taken1 && ($urandom_range(0, 99) < p_taken);
      pred_addr   = (pred_taken1 || pred_taken2) ? ($urandom & 32'hffff_fffc) : if_pc + 32'd8;
    end
    bus.inst_addr_ok = ($urandom_range(0, 99) < p_addr);
    bus.inst_data_ok = (fly_q.size() != 0) && ($urandom_range(0, 99) < p_data);
    if (bus.inst_data_ok) begin
      f = fly_q[0];
      bus.inst_rdata = data_of(f[65:34]);
    end else begin
      bus.inst_rdata = {$urandom, $urandom};
    end
    redirect_valid = f_redir || ($urandom_range(0, 99) < p_redir);
    redirect_pc    = f_redir ? f_redir_pc : ($urandom & 32'hffff_fffc);
    out_ready      = ($urandom_range(0, 99) < p_ready);
    #1;

    chk("inst_req", bus.inst_req, exp_req);
    chk("inst_addr", bus.inst_addr, cur);
    chk("if_pc", if_pc, model_pc);
    chk("state", dbg_state, hold_m ? ST_HOLD : ST_RUN);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      hm = exp_q[0];
      chk("out_pc", out_pc, hm[129:98]);
      chk("out_inst", {out_inst1, out_inst0}, hm[63:0]);
      chk("out_pred", {out_pred_taken1, out_pred_taken2, out_pred_addr}, hm[97:64]);
      chk("out_valid1", out_valid1, !hm[97]);
    end

    acc = exp_req && bus.inst_addr_ok;
    pop = (exp_q.size() != 0) && out_ready && !redirect_valid;
    if (pop) begin
      hm = exp_q.pop_front();
      consumed_q.push_back(hm[129:98]);
    end
    if (bus.inst_data_ok) begin
      f = fly_q.pop_front();
      if (f[66] && !redirect_valid) exp_q.push_back({f[65:0], bus.inst_rdata});
    end
    if (acc) issued_q.push_back(cur);
    if (redirect_valid) begin
      for (int i = 0; i < fly_q.size(); i++) begin
        f = fly_q[i]; f[66] = 1'b0; fly_q[i] = f;
      end
      exp_q.delete();
      if (acc) fly_q.push_back({1'b0, cur, 34'd0});
      if (!hold_m && exp_req && !acc) begin
        hold_m = 1'b1; hold_addr_m = cur;
      end else if (hold_m && acc) begin
        hold_m = 1'b0;
      end
      model_pc = redirect_pc;
    end else if (acc) begin
      if (hold_m) begin
        fly_q.push_back({1'b0, cur, 34'd0});
        hold_m = 1'b0;
      end else begin
        fly_q.push_back({1'b1, cur, pred_taken1, pred_taken2, pred_addr});
        model_pc = pred_addr;
      end
    end
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    pred_taken1 = 0; pred_taken2 = 0; pred_addr = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = '0;
    fly_q.delete(); exp_q.delete(); issued_q.delete(); consumed_q.delete();
    hold_m = 1'b0; hold_addr_m = '0; model_pc = RST_PC;
    f_redir = 0; ft_en = 0;
    @(negedge cpu_clk); #1;
    chk("rst_inst_req", bus.inst_req, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_if_pc", if_pc, RST_PC);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_valid1", out_valid1, 1'b0);
    chk("rst_state", dbg_state, ST_RUN);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
  endtask

  task automatic knobs(input int a, input int d, input int r, input int rd, input int t);
    p_addr = a; p_data = d; p_ready = r; p_redir = rd; p_taken = t;
  endtask

  initial begin
    // sequential fetch, no predictions
    knobs(100, 100, 100, 0, 0);
    do_reset();
    repeat (12) step();
    chk("seq_issue0", issued_q[0], 32'h1c00_0000);
    chk("seq_issue1", issued_q[1], 32'h1c00_0008);
    chk("seq_issue2", issued_q[2], 32'h1c00_0010);
    chk("seq_out0", consumed_q[0], 32'h1c00_0000);
    chk("seq_out2", consumed_q[2], 32'h1c00_0010);

    // slot-0 taken at 1c000008
    do_reset();
    knobs(100, 100, 100, 0, 0);
    ft_en = 1; ft_pc = 32'h1c00_0008; ft_target = 32'h1c00_0100;
    repeat (10) step();
    chk("taken_issue", issued_q[2], 32'h1c00_0100);
    chk("taken_out", consumed_q[1], 32'h1c00_0008);

    // decode stalled: queue fills and requests stop
    do_reset();
    knobs(100, 100, 0, 0, 0);
    repeat (10) step();
    chk("stall_issues", issued_q.size(), 4);
    p_ready = 100;
    repeat (6) step();
    chk("stall_resume", issued_q.size() > 4, 1'b1);

    // redirect with three outstanding (fourth accepted on the redirect cycle)
    do_reset();
    knobs(100, 0, 100, 0, 0);
    repeat (3) step();
    f_redir = 1; f_redir_pc = 32'h1c00_0200;
    step();
    f_redir = 0; p_data = 100;
    repeat (14) step();
    chk("redir_stale_issue", issued_q[3], 32'h1c00_0018);
    chk("redir_new_issue", issued_q[4], 32'h1c00_0200);
    chk("redir_first_out", consumed_q[0], 32'h1c00_0200);

    // redirect while a request waits for addr_ok
    do_reset();
    knobs(100, 0, 100, 0, 0);
    repeat (2) step();
    p_addr = 0; f_redir = 1; f_redir_pc = 32'h1c00_0200;
    step();
    f_redir = 0;
    repeat (2) step();
    p_addr = 100; p_data = 100;
    repeat (14) step();
    chk("hold_stale_issue", issued_q[2], 32'h1c00_0010);
    chk("hold_new_issue", issued_q[3], 32'h1c00_0200);
    chk("hold_first_out", consumed_q[0], 32'h1c00_0200);

    // redirect coincident with data_ok and addr_ok
    do_reset();
    knobs(100, 0, 100, 0, 0);
    repeat (2) step();
    p_data = 100; f_redir = 1; f_redir_pc = 32'h1c00_0200;
    step();
    f_redir = 0;
    repeat (15) step();
    chk("coin_first_out", consumed_q[0], 32'h1c00_0200);

    // randomized traffic, with one reset mid-stream
    do_reset();
    for (int blk = 0; blk < 60; blk++) begin
      knobs($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 100),
            $urandom_range(0, 8), $urandom_range(0, 40));
      if (blk == 30) do_reset();
      repeat (50) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
